piton_credit_tx: RTL and testbench

Credit-based transmit stage that feeds one OpenPiton-style router input port (data/valid/yummy channel) from an endpoint-side valid/ready producer. It buffers flits in a small FIFO and tracks downstream buffer credits. A flit is launched only when the router's input buffer is known to have space, and each returned `yummy` pulse restores one credit. It sits directly upstream of the mesh router local port: its outputs drive `data`/`valid` of the router's input channel, and it consumes the router's `yummy` for that port.

---
 rtl/piton_pkg.sv | 14 +
 rtl/piton_tx_fifo.sv | 53 +++++
 rtl/piton_credit_tx.sv | 97 +++++++++
 tb/tb_piton_credit_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/piton_pkg.sv
// rtl/piton_pkg.sv - shared constants and types for the piton credit transmit stage
package piton_pkg;

   localparam int PITON_FLIT_w        = 64;
   localparam int PITON_RTR_BUF_DEPTH = 4;

   typedef enum logic [1:0] {
      CR_HOLD,
      CR_DEC,
      CR_INC,
      CR_OVF
   } credit_op_e;

endpackage

// File: rtl/piton_tx_fifo.sv
// rtl/piton_tx_fifo.sv - generic synchronous FIFO with asynchronous active-low reset
module piton_tx_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   pop,
   output logic [DATA_W-1:0]      pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/piton_credit_tx.sv
// rtl/piton_credit_tx.sv - credit-based flit transmitter; PITON_CREDIT_TX_STATS_EN adds stat counters
module piton_credit_tx
   import piton_pkg::*;
#(
   parameter int DATA_W     = PITON_FLIT_w,
   parameter int CREDITS    = PITON_RTR_BUF_DEPTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_W-1:0]            dataOut,
   output logic                         validOut,
   input  logic                         yummyIn,
   output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
   output logic                         err_credit_ovf
`ifdef PITON_CREDIT_TX_STATS_EN
   ,
   output logic [31:0]                  stat_flits,
   output logic [31:0]                  stat_stall
`endif
);

   localparam int CW = $clog2(CREDITS+1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   logic                         fifo_full;
   logic                         fifo_empty;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic [DATA_W-1:0]            head;
   logic                         launch;
   credit_op_e                   credit_op;
   logic                         unused_fifo_count;

   assign unused_fifo_count = ^fifo_count;

   // in_ready comes from registered occupancy only, so a same-cycle pop never frees a slot
   assign in_ready = ~fifo_full;
   assign launch   = ~fifo_empty & (credit_cnt != '0);

   piton_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid & in_ready),
      .push_data (in_data),
      .pop       (launch),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      credit_op = CR_HOLD;
      case ({launch, yummyIn})
         2'b10:   credit_op = CR_DEC;
         2'b01:   credit_op = (credit_cnt == CRED_MAX) ? CR_OVF : CR_INC;
         default: credit_op = CR_HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credit_cnt     <= CRED_MAX;
         err_credit_ovf <= 1'b0;
         validOut       <= 1'b0;
         dataOut        <= '0;
      end else begin
         validOut <= launch;
         if (launch) dataOut <= head;
         case (credit_op)
            CR_DEC:  credit_cnt <= credit_cnt - 1'b1;
            CR_INC:  credit_cnt <= credit_cnt + 1'b1;
            CR_OVF:  err_credit_ovf <= 1'b1;
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

`ifdef PITON_CREDIT_TX_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_flits <= '0;
         stat_stall <= '0;
      end else begin
         if (launch) stat_flits <= stat_flits + 32'd1;
         if (~fifo_empty && credit_cnt == '0) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_piton_credit_tx.sv
// tb/tb_piton_credit_tx.sv - self-checking bench for piton_credit_tx
module tb_piton_credit_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] dataOut;
   logic        validOut;
   logic        yummyIn;
   logic [2:0]  credit_cnt;
   logic        err_credit_ovf;
`ifdef PITON_CREDIT_TX_STATS_EN
   logic [31:0] stat_flits;
   logic [31:0] stat_stall;
`endif

   piton_credit_tx dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .dataOut        (dataOut),
      .validOut       (validOut),
      .yummyIn        (yummyIn),
      .credit_cnt     (credit_cnt),
      .err_credit_ovf (err_credit_ovf)
`ifdef PITON_CREDIT_TX_STATS_EN
      ,
      .stat_flits     (stat_flits),
      .stat_stall     (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [63:0] d;
      logic        y;
      logic [2:0]  exp_cred;
      logic        exp_ready;
      logic        exp_valid;
      logic        exp_err;
   } step_t;

   step_t       tbl [25];
   logic [63:0] exp_q [$];
   logic [63:0] last_data;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic step_t mk(input logic v, input logic [63:0] d, input logic y,
                                input logic [2:0] c, input logic r, input logic vo, input logic e);
      step_t s;
      s.v = v; s.d = d; s.y = y;
      s.exp_cred = c; s.exp_ready = r; s.exp_valid = vo; s.exp_err = e;
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_flit();
      logic [63:0] e;
      if (validOut) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_flit: got %0h expected no flit", dataOut);
         end else begin
            e = exp_q.pop_front();
            chk("flit_data", dataOut, e);
            last_data = e;
         end
      end else begin
         chk("data_hold", dataOut, last_data);
      end
   endtask

   task automatic cycle(input logic v, input logic [63:0] d, input logic y);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      yummyIn  = y;
      #1;
      if (v && in_ready) exp_q.push_back(d);
      @(posedge clk);
      #1;
      check_flit();
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; yummyIn = 1'b0;
      last_data = '0;

      tbl[0]  = mk(1, 64'hA0, 0, 4, 1, 0, 0);
      tbl[1]  = mk(1, 64'hA1, 0, 3, 1, 1, 0);
      tbl[2]  = mk(1, 64'hA2, 0, 2, 1, 1, 0);
      tbl[3]  = mk(1, 64'hA3, 0, 1, 1, 1, 0);
      tbl[4]  = mk(0, 64'h00, 0, 0, 1, 1, 0);
      tbl[5]  = mk(0, 64'h00, 0, 0, 1, 0, 0);
      tbl[6]  = mk(1, 64'hB0, 0, 0, 1, 0, 0);
      tbl[7]  = mk(1, 64'hB1, 0, 0, 1, 0, 0);
      tbl[8]  = mk(1, 64'hB2, 0, 0, 1, 0, 0);
      tbl[9]  = mk(1, 64'hB3, 0, 0, 0, 0, 0);
      tbl[10] = mk(1, 64'hC0, 0, 0, 0, 0, 0);
      tbl[11] = mk(0, 64'h00, 1, 1, 0, 0, 0);
      tbl[12] = mk(0, 64'h00, 0, 0, 1, 1, 0);
      tbl[13] = mk(0, 64'h00, 0, 0, 1, 0, 0);
      tbl[14] = mk(0, 64'h00, 1, 1, 1, 0, 0);
      tbl[15] = mk(0, 64'h00, 1, 1, 1, 1, 0);
      tbl[16] = mk(0, 64'h00, 0, 0, 1, 1, 0);
      tbl[17] = mk(0, 64'h00, 0, 0, 1, 0, 0);
      tbl[18] = mk(0, 64'h00, 1, 1, 1, 0, 0);
      tbl[19] = mk(0, 64'h00, 1, 1, 1, 1, 0);
      tbl[20] = mk(0, 64'h00, 1, 2, 1, 0, 0);
      tbl[21] = mk(0, 64'h00, 1, 3, 1, 0, 0);
      tbl[22] = mk(0, 64'h00, 1, 4, 1, 0, 0);
      tbl[23] = mk(0, 64'h00, 1, 4, 1, 0, 1);
      tbl[24] = mk(0, 64'h00, 0, 4, 1, 0, 1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",  validOut, 0);
      chk("rst_data",   dataOut, 0);
      chk("rst_credit", credit_cnt, 4);
      chk("rst_err",    err_credit_ovf, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_ready", in_ready, 1);

      for (int i = 0; i < 25; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].y);
         chk($sformatf("step%0d_credit", i), credit_cnt, tbl[i].exp_cred);
         chk($sformatf("step%0d_ready",  i), in_ready,   tbl[i].exp_ready);
         chk($sformatf("step%0d_valid",  i), validOut,   tbl[i].exp_valid);
         chk($sformatf("step%0d_err",    i), err_credit_ovf, tbl[i].exp_err);
      end

      // drain credits, then queue three flits and reset in the middle of the burst
      for (int i = 0; i < 4; i++) cycle(1, 64'hE0 + 64'(i), 0);
      for (int i = 0; i < 3; i++) cycle(1, 64'hD0 + 64'(i), 0);
      chk("pre_rst_credit", credit_cnt, 0);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid",  validOut, 0);
      chk("mid_rst_data",   dataOut, 0);
      chk("mid_rst_credit", credit_cnt, 4);
      chk("mid_rst_err",    err_credit_ovf, 0);
      chk("mid_rst_ready",  in_ready, 1);
      exp_q.delete();
      last_data = '0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) cycle(0, 64'h0, 0);
      chk("post_rst_credit", credit_cnt, 4);
      cycle(1, 64'hF0, 0);
      chk("f0_not_yet", validOut, 0);
      cycle(0, 64'h0, 0);
      chk("f0_valid", validOut, 1);
      cycle(0, 64'h0, 0);

`ifdef PITON_CREDIT_TX_STATS_EN
      @(negedge clk);
      in_valid = 1'b0; yummyIn = 1'b0;
      reset = 1'b0;
      #1;
      chk("stat_flits_rst", stat_flits, 0);
      chk("stat_stall_rst", stat_stall, 0);
      exp_q.delete();
      last_data = '0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) cycle(1, 64'h50 + 64'(i), 0);
      for (int i = 0; i < 5; i++) cycle(0, 64'h0, 0);
      cycle(0, 64'h0, 1);
      for (int i = 5; i < 10; i++) cycle(1, 64'h50 + 64'(i), 1);
      cycle(0, 64'h0, 1);
      cycle(0, 64'h0, 0);
      cycle(0, 64'h0, 0);
      chk("stat_flits", stat_flits, 10);
      chk("stat_stall", stat_stall, 6);
      chk("stat_credit", credit_cnt, 1);
`endif

      chk("sb_empty", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
